// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, line refill over a
// word-per-beat req/ack bus, and whole-cache invalidation on flush.
module inst_cache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_inst_o,
    output logic        rd_valid_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    localparam int unsigned OB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = 32 - IB - OB - 2;
    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [OB-1:0] LastBeat = OB'(WORDS - 1);

    typedef enum logic {StIdle, StRefill} state_e;

    state_e          state_q;
    logic [LINES-1:0] valid_q;
    logic            flush_pend_q;
    logic [OB-1:0]   cnt_q;
    logic [IB-1:0]   ridx_q;
    logic [TW-1:0]   rtag_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;

    logic [TW-1:0]   tag_q  [LINES];
    logic [31:0]     data_q [LINES][WORDS];

    logic [OB-1:0]   off;
    logic [IB-1:0]   idx;
    logic [TW-1:0]   tag;
    logic            hit;
    logic            last_beat;
    logic            unused_addr;

    assign off         = rd_addr_i[OB+1:2];
    assign idx         = rd_addr_i[OB+IB+1:OB+2];
    assign tag         = rd_addr_i[31:OB+IB+2];
    assign unused_addr = ^rd_addr_i[1:0];

    // Flush forces a miss in its own cycle so a stale line is never returned.
    assign hit = (state_q == StIdle) && rd_req_i && !flush_i && valid_q[idx] && (tag_q[idx] == tag);
    assign last_beat = (state_q == StRefill) && mem_ack_i && (cnt_q == LastBeat);

    always_comb begin
        rd_valid_o = hit;
        rd_inst_o  = hit ? data_q[idx][off] : Nop;
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            ridx_q       <= '0;
            rtag_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (rd_req_i && !hit && !flush_i) begin
                        ridx_q     <= idx;
                        rtag_q     <= tag;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {rd_addr_i[31:OB+2], {(OB + 2){1'b0}}};
                        state_q    <= StRefill;
                    end
                end
                StRefill: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        cnt_q      <= cnt_q + 1'b1;
                        mem_addr_q <= mem_addr_q + 32'd4;
                    end
                    if (last_beat) begin
                        // A flush seen at any point of the refill leaves the line invalid.
                        if (!flush_pend_q && !flush_i) begin
                            valid_q[ridx_q] <= 1'b1;
                        end
                        flush_pend_q <= 1'b0;
                        mem_req_q    <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == StRefill) && mem_ack_i) begin
            data_q[ridx_q][cnt_q] <= mem_rdata_i;
        end
        if (last_beat) begin
            tag_q[ridx_q] <= rtag_q;
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected refill beats are queued at each miss and
// consumed by the memory model as the DUT presents them.
module tb_inst_cache;
    localparam int WORDS = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [31:0] rd_inst;
    logic        rd_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    bit stall_mode = 1'b0;
    int sc = 0;
    logic [31:0] exp_q[$];

    inst_cache #(.LINES(16), .WORDS(WORDS)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_inst_o  (rd_inst),
        .rd_valid_o (rd_valid),
        .flush_i    (flush),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_rdata_i(mem_rdata),
        .mem_ack_i  (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory returns the byte address of each word as its data.
    assign mem_rdata = mem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_req && stall_mode) begin
            mem_ack = (sc == 2);
            sc = (sc == 2) ? 0 : sc + 1;
        end else if (mem_req) begin
            mem_ack = 1'b1;
        end else begin
            mem_ack = 1'b0;
            sc = 0;
        end
        #1;
        if (mem_req) begin
            if (exp_q.size() == 0) check("spurious_req", 32'(mem_req), 32'd0);
            else if (mem_ack) check("beat_addr", mem_addr, exp_q.pop_front());
            else check("hold_addr", mem_addr, exp_q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < WORDS; i++) exp_q.push_back({a[31:4], 4'h0} + 32'(i * 4));
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit miss, input int lat);
        int n;
        step();
        rd_req  = 1'b1;
        rd_addr = a;
        if (miss) push_line(a);
        #2;
        n = 0;
        while (!rd_valid && n < 100) begin
            if (n == 0) check("miss_nop", rd_inst, NOP);
            step();
            #2;
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("inst", rd_inst, a);
        check("beats_left", 32'(exp_q.size()), 32'd0);
        rd_req = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; flush = 1'b0; mem_ack = 1'b0;
        step(); step();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_inst", rd_inst, NOP);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // Cold miss then hits across the line
        do_fetch(32'h1008, 1'b1, WORDS + 1);
        for (int i = 0; i < WORDS; i++) begin
            do_fetch(32'h1000 + 32'(i * 4), 1'b0, 0);
            check("hit_no_req", 32'(mem_req), 32'd0);
        end

        // Conflict misses on index 0
        do_fetch(32'h1100, 1'b1, WORDS + 1);
        do_fetch(32'h1000, 1'b1, WORDS + 1);

        // Stalled memory: acks in cycles 3,6,9,12, hit in cycle 13
        stall_mode = 1'b1;
        do_fetch(32'h2044, 1'b1, 13);
        stall_mode = 1'b0;

        // Flush in idle
        do_fetch(32'h1000, 1'b0, 0);
        step();
        flush = 1'b1; rd_req = 1'b1; rd_addr = 32'h1000;
        #2;
        check("flush_valid", 32'(rd_valid), 32'd0);
        check("flush_inst", rd_inst, NOP);
        step();
        flush = 1'b0; rd_req = 1'b0;
        #2;
        check("flush_no_refill", 32'(mem_req), 32'd0);
        do_fetch(32'h1000, 1'b1, WORDS + 1);

        // Flush at beat 2 of a refill; address change must not disturb it
        step();
        rd_req = 1'b1; rd_addr = 32'h3000;
        push_line(32'h3000);
        step(); step(); step();
        flush = 1'b1; rd_addr = 32'h4000;
        #2;
        check("refill_valid", 32'(rd_valid), 32'd0);
        step();
        flush = 1'b0; rd_req = 1'b0;
        n = 0;
        while (mem_req && n < 20) begin
            step();
            n++;
        end
        check("flush_refill_done", 32'(exp_q.size()), 32'd0);
        do_fetch(32'h3000, 1'b1, WORDS + 1);

        // Reset at beat 2 of a refill
        step();
        rd_req = 1'b1; rd_addr = 32'h5000;
        push_line(32'h5000);
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_valid", 32'(rd_valid), 32'd0);
        exp_q.delete();
        step();
        rst = 1'b0; rd_req = 1'b0;
        do_fetch(32'h5000, 1'b1, WORDS + 1);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
